// File: rtl/openram_march_bist.sv
// March C- BIST sequencer driving port 0 of one OpenRAM test-chip macro.
// Records the first miscompare and counts all of them; every output is registered.
module openram_march_bist #(
  parameter int ADDR_SIZE  = 16,
  parameter int DATA_SIZE  = 32,
  parameter int WMASK_SIZE = 4,
  parameter int MAX_CHIPS  = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                  la_clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [3:0]            sram_sel,
  input  logic [ADDR_SIZE-1:0]  addr_max,
  input  logic [DATA_SIZE-1:0]  pattern,
  input  logic [DATA_SIZE-1:0]  cmp_mask,
  input  logic [DATA_SIZE-1:0]  dout0,
  output logic [MAX_CHIPS-1:0]  csb0,
  output logic                  web0,
  output logic [WMASK_SIZE-1:0] wmask0,
  output logic [ADDR_SIZE-1:0]  addr0,
  output logic [DATA_SIZE-1:0]  din0,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_SIZE-1:0]  fail_addr,
  output logic [DATA_SIZE-1:0]  fail_data,
  output logic [2:0]            fail_elem,
  output logic [7:0]            err_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] NEXT  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [2:0] LAST_ELEM = 3'd5;

  // March C- element properties: M0 w0, M1 r0w1, M2 r1w0, M3 r0w1 (down), M4 r1w0 (down), M5 r0.
  function automatic logic elem_has_read(input logic [2:0] e);
    return e != 3'd0;
  endfunction

  function automatic logic elem_has_write(input logic [2:0] e);
    return e != LAST_ELEM;
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_read_inv(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic elem_write_inv(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  logic [2:0]           state, nstate;
  logic [2:0]           elem, nelem;
  logic [ADDR_SIZE-1:0] addr, naddr;
  logic [1:0]           wcnt, nwcnt;
  logic [3:0]           sel_q, nsel;
  logic [ADDR_SIZE-1:0] amax_q, namax;
  logic [DATA_SIZE-1:0] pat_q, npat;
  logic [DATA_SIZE-1:0] mask_q, nmask;
  logic                 accept;
  logic                 compare;
  logic                 step;
  logic                 last_addr;
  logic [DATA_SIZE-1:0] exp_data;
  logic                 miscompare;
  logic [DATA_SIZE-1:0] wdata;

  assign last_addr  = elem_down(elem) ? (addr == '0) : (addr == amax_q);
  assign exp_data   = elem_read_inv(elem) ? ~pat_q : pat_q;
  assign miscompare = compare && (((dout0 ^ exp_data) & mask_q) != '0);
  assign wdata      = elem_write_inv(nelem) ? ~npat : npat;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    nstate  = state;
    nelem   = elem;
    naddr   = addr;
    nwcnt   = wcnt;
    nsel    = sel_q;
    namax   = amax_q;
    npat    = pat_q;
    nmask   = mask_q;
    accept  = 1'b0;
    compare = 1'b0;
    step    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nsel   = sram_sel;
          namax  = addr_max;
          npat   = pattern;
          nmask  = cmp_mask;
          nelem  = 3'd0;
          naddr  = '0;
          nstate = WRITE;
        end
      end
      WRITE: step = 1'b1;
      READ: begin
        nwcnt  = 2'd0;
        nstate = (READ_LAT == 1) ? CHECK : WAIT;
      end
      WAIT: begin
        if (wcnt == 2'(READ_LAT - 2)) nstate = CHECK;
        else                          nwcnt  = wcnt + 2'd1;
      end
      CHECK: begin
        compare = 1'b1;
        if (elem_has_write(elem)) nstate = WRITE;
        else                      step   = 1'b1;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase

    // Address/element advance folds into the final cycle of an op, so NEXT never costs a cycle.
    if (step) begin
      nstate = NEXT;
      if (last_addr) begin
        if (elem == LAST_ELEM) begin
          nstate = DONE;
        end else begin
          nelem = elem + 3'd1;
          naddr = elem_down(nelem) ? amax_q : '0;
        end
      end else begin
        naddr = elem_down(elem) ? addr - 1'b1 : addr + 1'b1;
      end
      if (nstate == NEXT) nstate = elem_has_read(nelem) ? READ : WRITE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge la_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      elem      <= 3'd0;
      addr      <= '0;
      wcnt      <= 2'd0;
      sel_q     <= 4'd0;
      amax_q    <= '0;
      pat_q     <= '0;
      mask_q    <= '0;
      csb0      <= '1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= 3'd0;
      err_count <= 8'd0;
    end else begin
      state  <= nstate;
      elem   <= nelem;
      addr   <= naddr;
      wcnt   <= nwcnt;
      sel_q  <= nsel;
      amax_q <= namax;
      pat_q  <= npat;
      mask_q <= nmask;

      // Port drive is registered from the next state so the access is live in its own cycle.
      csb0   <= ((nstate == WRITE) || (nstate == READ)) ? ~(MAX_CHIPS'(1) << nsel) : '1;
      web0   <= (nstate != WRITE);
      wmask0 <= (nstate == WRITE) ? '1 : '0;
      addr0  <= naddr;
      if (nstate == WRITE) din0 <= wdata;
      busy   <= (nstate == WRITE) || (nstate == READ) || (nstate == WAIT) || (nstate == CHECK);

      if (accept) begin
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_elem <= 3'd0;
        err_count <= 8'd0;
      end else begin
        if (nstate == DONE) done <= 1'b1;
        if (miscompare) begin
          fail <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (!fail) begin
            fail_addr <= addr;
            fail_data <= dout0;
            fail_elem <= elem;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_openram_march_bist.sv
// Self-checking bench: two BIST instances (READ_LAT 1 and 2) against SRAM models with injectable faults.
// Expected traffic and status come from a March C- reference walk over a plain array.
module tb_openram_march_bist;

  typedef logic [52:0] op_t;  // {web, wmask, addr, write data or 0}

  logic        la_clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [3:0]  sram_sel;
  logic [15:0] addr_max;
  logic [31:0] pattern, cmp_mask;
  logic [31:0] dout_a, dout_b;

  logic [15:0] csb_a, csb_b, addr_a, addr_b, faddr_a, faddr_b;
  logic        web_a, web_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b;
  logic [3:0]  wmask_a, wmask_b;
  logic [31:0] din_a, din_b, fdata_a, fdata_b;
  logic [2:0]  felem_a, felem_b;
  logic [7:0]  err_a, err_b;

  openram_march_bist #(.READ_LAT(1)) dut_a (
    .la_clk(la_clk), .reset_n(reset_n), .start(start_a), .sram_sel(sram_sel),
    .addr_max(addr_max), .pattern(pattern), .cmp_mask(cmp_mask), .dout0(dout_a),
    .csb0(csb_a), .web0(web_a), .wmask0(wmask_a), .addr0(addr_a), .din0(din_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .fail_addr(faddr_a),
    .fail_data(fdata_a), .fail_elem(felem_a), .err_count(err_a)
  );

  openram_march_bist #(.READ_LAT(2)) dut_b (
    .la_clk(la_clk), .reset_n(reset_n), .start(start_b), .sram_sel(sram_sel),
    .addr_max(addr_max), .pattern(pattern), .cmp_mask(cmp_mask), .dout0(dout_b),
    .csb0(csb_b), .web0(web_b), .wmask0(wmask_b), .addr0(addr_b), .din0(din_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .fail_addr(faddr_b),
    .fail_data(fdata_b), .fail_elem(felem_b), .err_count(err_b)
  );

  always #5 la_clk = ~la_clk;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur_test = "reset";

  // Fault environment applied to every read of the selected macro.
  int          stuck_addr = -1;
  logic [31:0] stuck_or   = '0;
  logic [31:0] clr_mask   = '0;
  logic [31:0] tie_hi     = '0;

  function automatic logic [31:0] rd_fault(input int a, input logic [31:0] v);
    logic [31:0] r;
    r = v;
    if (a == stuck_addr) r = r | stuck_or;
    r = (r & ~clr_mask) | tie_hi;
    return r;
  endfunction

  // SRAM models; B delivers data only after one extra cycle and shows garbage before that.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic        pend_b = 1'b0;
  logic [31:0] data_b;

  initial begin
    dout_a = '0;
    dout_b = '0;
  end

  always @(posedge la_clk) begin
    if (!csb_a[sram_sel]) begin
      if (!web_a) mem_a[addr_a[5:0]] <= din_a;
      else        dout_a <= rd_fault(int'(addr_a), mem_a[addr_a[5:0]]);
    end
  end

  always @(posedge la_clk) begin
    if (!csb_b[sram_sel] && !web_b) mem_b[addr_b[5:0]] <= din_b;
    if (!csb_b[sram_sel] && web_b) begin
      pend_b <= 1'b1;
      data_b <= rd_fault(int'(addr_b), mem_b[addr_b[5:0]]);
      dout_b <= $urandom;
    end else if (pend_b) begin
      dout_b <= data_b;
      pend_b <= 1'b0;
    end
  end

  // Monitors: busy cycles, every issued access, and any illegal chip-select pattern.
  int  busy_cnt_a = 0, busy_cnt_b = 0, bad_csb_a = 0, bad_csb_b = 0;
  op_t obs_a[$];
  op_t obs_b[$];

  always @(negedge la_clk) begin
    if (busy_a === 1'b1) busy_cnt_a <= busy_cnt_a + 1;
    if (csb_a !== '1) begin
      obs_a.push_back({web_a, wmask_a, addr_a, web_a ? 32'h0 : din_a});
      if (csb_a !== ~(16'(1) << sram_sel)) bad_csb_a <= bad_csb_a + 1;
    end
  end

  always @(negedge la_clk) begin
    if (busy_b === 1'b1) busy_cnt_b <= busy_cnt_b + 1;
    if (csb_b !== '1) begin
      obs_b.push_back({web_b, wmask_b, addr_b, web_b ? 32'h0 : din_b});
      if (csb_b !== ~(16'(1) << sram_sel)) bad_csb_b <= bad_csb_b + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s:%s observed=%0h expected=%0h", cur_test, tag, observed, expected);
    end
  endtask

  // Reference: walk March C- element by element over a plain array.
  op_t         exp_ops[$];
  int          exp_busy, exp_err;
  logic        exp_fail;
  logic [15:0] exp_faddr;
  logic [31:0] exp_fdata;
  logic [2:0]  exp_felem;

  task automatic build_model(input int amax, input int lat);
    logic [31:0] rm [64];
    int          n, a;
    logic [31:0] v, e;
    int          down [6] = '{0, 0, 0, 1, 1, 0};
    int          rd   [6] = '{-1, 0, 1, 0, 1, 0};   // -1 none, 0 expects pattern, 1 expects ~pattern
    int          wr   [6] = '{0, 1, 0, 1, 0, -1};
    n = amax + 1;
    exp_ops.delete();
    exp_busy  = n * (5 * lat + 10);
    exp_err   = 0;
    exp_fail  = 1'b0;
    exp_faddr = '0;
    exp_fdata = '0;
    exp_felem = '0;
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k < n; k++) begin
        a = (down[el] != 0) ? (n - 1 - k) : k;
        if (rd[el] >= 0) begin
          e = (rd[el] == 1) ? ~pattern : pattern;
          v = rd_fault(a, rm[a]);
          exp_ops.push_back({1'b1, 4'h0, 16'(a), 32'h0});
          if (((v ^ e) & cmp_mask) != 0) begin
            if (exp_err < 255) exp_err++;
            if (!exp_fail) begin
              exp_faddr = 16'(a);
              exp_fdata = v;
              exp_felem = 3'(el);
            end
            exp_fail = 1'b1;
          end
        end
        if (wr[el] >= 0) begin
          e = (wr[el] == 1) ? ~pattern : pattern;
          rm[a] = e;
          exp_ops.push_back({1'b0, 4'hF, 16'(a), e});
        end
      end
    end
  endtask

  int base_busy, base_ops;

  // Called at a negedge with the target instance idle.
  task automatic launch(input int which, input int amax);
    addr_max = 16'(amax);
    build_model(amax, (which == 0) ? 1 : 2);
    base_busy = (which == 0) ? busy_cnt_a : busy_cnt_b;
    base_ops  = (which == 0) ? obs_a.size() : obs_b.size();
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(negedge la_clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which);
    for (int i = 0; i < 4000; i++) begin
      @(negedge la_clk);
      if (((which == 0) ? done_a : done_b) === 1'b1) break;
    end
    @(negedge la_clk);
  endtask

  task automatic final_checks(input int which);
    int bad, nobs;
    op_t o;
    nobs = ((which == 0) ? obs_a.size() : obs_b.size()) - base_ops;
    check("busy_cycles", ((which == 0) ? busy_cnt_a : busy_cnt_b) - base_busy, exp_busy);
    check("op_count", nobs, exp_ops.size());
    bad = 0;
    for (int i = 0; i < nobs && i < exp_ops.size(); i++) begin
      o = (which == 0) ? obs_a[base_ops + i] : obs_b[base_ops + i];
      if (o !== exp_ops[i]) bad++;
    end
    check("op_seq_mismatches", bad, 0);
    check("bad_csb", (which == 0) ? bad_csb_a : bad_csb_b, 0);
    if (which == 0) begin
      check("busy", busy_a, 1'b0);
      check("done", done_a, 1'b1);
      check("fail", fail_a, exp_fail);
      check("err_count", err_a, exp_err);
      check("fail_addr", faddr_a, exp_faddr);
      check("fail_data", fdata_a, exp_fdata);
      check("fail_elem", felem_a, exp_felem);
    end else begin
      check("busy", busy_b, 1'b0);
      check("done", done_b, 1'b1);
      check("fail", fail_b, exp_fail);
      check("err_count", err_b, exp_err);
      check("fail_addr", faddr_b, exp_faddr);
      check("fail_data", fdata_b, exp_fdata);
      check("fail_elem", felem_b, exp_felem);
    end
  endtask

  task automatic run_test(input int which, input int amax);
    launch(which, amax);
    wait_done(which);
    final_checks(which);
  endtask

  task automatic clear_faults();
    stuck_addr = -1;
    stuck_or   = '0;
    clr_mask   = '0;
    tie_hi     = '0;
  endtask

  task automatic check_reset_a();
    check("rst_csb0", csb_a, 16'hFFFF);
    check("rst_web0", web_a, 1'b1);
    check("rst_wmask0", wmask_a, 4'h0);
    check("rst_addr0", addr_a, 16'h0);
    check("rst_din0", din_a, 32'h0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_fail", fail_a, 1'b0);
    check("rst_err", err_a, 8'h0);
    check("rst_fail_info", {faddr_a, fdata_a, felem_a}, 51'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    sram_sel = 4'd1;
    addr_max = '0;
    pattern  = '0;
    cmp_mask = '1;
    repeat (3) @(negedge la_clk);
    check_reset_a();
    check("rst_b_csb0", csb_b, 16'hFFFF);
    check("rst_b_status", {busy_b, done_b, fail_b, err_b}, 11'h0);
    reset_n = 1'b1;
    @(negedge la_clk);

    cur_test = "good";
    run_test(0, 3);

    cur_test = "stuck_bit5";
    stuck_addr = 2;
    stuck_or   = 32'h20;
    run_test(0, 3);
    clear_faults();

    cur_test = "mask_ok";
    sram_sel = 4'd0;
    cmp_mask = 32'hFF;
    pattern  = 32'hA5;
    tie_hi   = 32'hFFFF_FF00;
    run_test(0, 3);

    cur_test = "mask_bit3_low";
    clr_mask = 32'h8;
    run_test(0, 3);
    clear_faults();

    cur_test = "lat2_single";
    sram_sel = 4'd1;
    cmp_mask = '1;
    pattern  = 32'hDEAD_BEEF;
    run_test(1, 0);

    cur_test = "reset_mid_m3";
    pattern    = '0;
    stuck_addr = 2;
    stuck_or   = 32'h20;
    launch(0, 3);
    for (int i = 0; i < 200; i++) begin
      if (busy_cnt_a - base_busy >= 32) break;
      @(negedge la_clk);
    end
    check("fail_before_reset", fail_a, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_a();
    @(negedge la_clk);
    reset_n = 1'b1;
    clear_faults();
    run_test(0, 3);

    cur_test = "ignored_starts";
    launch(0, 3);
    for (int i = 0; i < 200; i++) begin
      if (busy_cnt_a - base_busy >= 10) break;
      @(negedge la_clk);
    end
    sram_sel = 4'd1;
    start_a  = 1'b1;
    @(negedge la_clk);
    start_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge la_clk);
      if (busy_a === 1'b0) break;
    end
    start_a = 1'b1;
    @(negedge la_clk);
    start_a = 1'b0;
    check("fall_start_done_held", done_a, 1'b1);
    check("fall_start_busy_low", busy_a, 1'b0);
    final_checks(0);
    launch(0, 3);
    check("accepted_clears_done", done_a, 1'b0);
    check("accepted_busy", busy_a, 1'b1);
    wait_done(0);
    final_checks(0);

    for (int r = 0; r < 8; r++) begin
      int which, amax;
      cur_test = $sformatf("random%0d", r);
      which    = (r < 6) ? 0 : 1;
      amax     = (which == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      sram_sel = 4'($urandom_range(0, 15));
      pattern  = $urandom;
      cmp_mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : ($urandom | 32'h1);
      clear_faults();
      if ($urandom_range(0, 3) != 0) begin
        stuck_addr = $urandom_range(0, amax);
        stuck_or   = 32'h1 << $urandom_range(0, 31);
      end
      run_test(which, amax);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/openram_march_bist.md
Name: openram_march_bist

Overview:
- Built-in self-test sequencer for the OpenRAM test-chip SRAM macros.
- Runs a March C- algorithm over address range 0..addr_max of one selected macro through its port 0 (csb0/web0/wmask0/addr0/din0/dout0).
- Records the first miscompare and counts all miscompares.
- Sits beside the LA/GPIO scan controller; the top level muxes this block's port-0 drive onto the left or right SRAM bus when BIST is enabled.

Parameters:
- ADDR_SIZE, 16, address bus width.
- DATA_SIZE, 32, data bus width.
- WMASK_SIZE, 4, write-mask width.
- MAX_CHIPS, 16, number of one-hot chip selects.
- READ_LAT, 1, idle cycles between read issue and dout sample (1..3).

Ports:
- la_clk  in  1  block clock; the selected SRAM is clocked by the same clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; honoured only in IDLE.
- sram_sel  in  4  macro under test; latched on start.
- addr_max  in  ADDR_SIZE  last address tested; latched on start.
- pattern  in  DATA_SIZE  background "0" data; "1" is ~pattern; latched on start.
- cmp_mask  in  DATA_SIZE  1 = bit compared; latched on start (e.g. 32'hFF for the 8-bit macro).
- dout0  in  DATA_SIZE  read data from the selected macro (externally muxed).
- csb0  out  MAX_CHIPS  active-low chip selects, at most one low.
- web0  out  1  0 = write.
- wmask0  out  WMASK_SIZE  write mask.
- addr0  out  ADDR_SIZE  address.
- din0  out  DATA_SIZE  write data.
- busy  out  1  test in progress.
- done  out  1  sticky completion flag; cleared by the next accepted start.
- fail  out  1  sticky, set on any miscompare.
- fail_addr  out  ADDR_SIZE  address of the first miscompare.
- fail_data  out  DATA_SIZE  raw dout0 captured at the first miscompare.
- fail_elem  out  3  march element (0..5) of the first miscompare.
- err_count  out  8  miscompare count, saturates at 255.

Behaviour:
- Reset (asynchronous, any state):
  - csb0 = all ones, web0 = 1, wmask0 = 0, addr0 = 0, din0 = 0.
  - busy = done = fail = 0, fail_addr = fail_data = fail_elem = err_count = 0.
  - FSM returns to IDLE. Reset mid-test abandons the test; no partial status is kept.
- All outputs are registered. While no access is issued, csb0 is all ones and web0 = 1.
- FSM states: IDLE, WRITE, READ, WAIT, CHECK, NEXT, DONE.
- Start handling:
  - IDLE + start: latch inputs; clear done, fail, err_count and the fail_* registers.
  - Enter element M0 at address 0; busy = 1 from the next cycle.
  - start while busy is ignored.
- March elements, with N = addr_max + 1:
  - M0: up, w0.
  - M1: up, r0 then w1.
  - M2: up, r1 then w0.
  - M3: down, r0 then w1.
  - M4: down, r1 then w0.
  - M5: up, r0.
- Addressing:
  - "Up" runs 0→addr_max; "down" runs addr_max→0.
  - Each element terminates at its last address with no wrap or underflow.
  - addr_max = 0 is legal (N = 1).
- Write op: 1 cycle; csb0[sel] = 0, web0 = 0, wmask0 = all ones, din0 = expected data.
- Read op:
  - 1 issue cycle (csb0[sel] = 0, web0 = 1), then READ_LAT idle cycles.
  - dout0 is sampled on the edge ending the last idle cycle.
  - Compare rule: (dout0 ^ expected) & cmp_mask ≠ 0 → miscompare.
- Miscompare handling:
  - err_count increments and saturates at 255; fail is set.
  - fail_addr, fail_data and fail_elem load only if fail was previously 0.
  - The test continues to the end; there is no stop-on-fail.
- Read-then-write at the same address: the write issues in the cycle after the compare edge.
- Cycle budget: busy is high for exactly N·(5·READ_LAT+10) cycles. READ_LAT = 1 gives 15N.
- Completion: the cycle after the final M5 compare, busy = 0 and done = 1; return to IDLE.
- Status outputs hold until the next accepted start or reset.
- Start in the same cycle busy falls: not accepted; start is accepted from the following cycle.

Test Plan:
- Reset, then start with sram_sel = 1, addr_max = 3, pattern = 32'h0, cmp_mask = all ones, good SRAM model → busy high 60 cycles, done = 1, fail = 0, err_count = 0; csb0 only ever 16'hFFFD or 16'hFFFF.
- Same setup, model with bit 5 of address 2 stuck-at-1 → fail = 1, fail_addr = 2, fail_elem = 1, fail_data = 32'h20, err_count = 3 (M1, M3, M5).
- sram_sel = 0, cmp_mask = 32'hFF, dout0[31:8] tied to 1s, pattern = 32'hA5 → fail = 0; tie dout0[3] to 0 → fail = 1, fail_elem = 2.
- addr_max = 0, READ_LAT = 2, pattern = 32'hDEADBEEF → busy 20 cycles; address sequence always 0; din0 alternates 32'hDEADBEEF / 32'h21524110 per element.
- Assert reset_n low mid-M3 → outputs return to reset values asynchronously; a new start reruns from M0 at address 0 and completes with done = 1.
- Pulse start at busy cycle 10, and again on the cycle busy falls → both ignored; a start one cycle later is accepted and clears done.
